// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 max-pool over one IMG_W x IMG_H raster frame.
// Define MAXPOOL_SIGNED_EN to compare pixels as two's-complement (default unsigned).

module max_pool_stream #(
   parameter int unsigned DATA_W = 5,
   parameter int unsigned IMG_W  = 8,
   parameter int unsigned IMG_H  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              maxPoolingDone
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned LW = IMG_W / 2;
   localparam int unsigned HW = (LW > 1) ? $clog2(LW) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [DATA_W-1:0] h_reg;
   logic [DATA_W-1:0] linebuf [LW];
   logic [DATA_W-1:0] pair;
   logic [HW-1:0]     lb_idx;
   logic              accept, last_col, last_row, load_out;

   function automatic logic [DATA_W-1:0] pmax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
      return ($signed(a) > $signed(b)) ? a : b;
`else
      return (a > b) ? a : b;
`endif
   endfunction

   assign in_ready       = (state_q == StRun) && (!out_valid || out_ready);
   assign accept         = in_valid && in_ready;
   assign last_col       = (col_q == CW'(IMG_W - 1));
   assign last_row       = (row_q == RW'(IMG_H - 1));
   assign pair           = pmax(h_reg, in_data);
   assign lb_idx         = HW'(col_q >> 1);
   // Odd column of an odd row completes a 2x2 window.
   assign load_out       = accept && col_q[0] && row_q[0];
   assign busy           = (state_q == StRun) || (state_q == StDrain);
   assign maxPoolingDone = (state_q == StDone);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StRun: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     row_d   = '0;
                     state_d = StDrain;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         StDrain: begin
            if (out_valid && out_ready && out_last) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         col_q     <= '0;
         row_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if (load_out) begin
            out_data  <= pmax(linebuf[lb_idx], pair);
            out_valid <= 1'b1;
            out_last  <= last_row && last_col;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // Pixel datapath storage needs no reset; it is always written before being read.
   always_ff @(posedge clk) begin
      if (accept && !col_q[0]) h_reg <= in_data;
      if (accept && col_q[0] && !row_q[0]) linebuf[lb_idx] <= pair;
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream: 4x4 frames, queue-based reference model,
// directed cases plus randomized pixels, input gaps and output backpressure.

module tb_max_pool_stream;

   localparam int unsigned DW = 5;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 4;
   localparam int unsigned N  = W * H;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          busy;
   logic          maxPoolingDone;

   int            checks = 0;
   int            errors = 0;
   int            rdy_mode = 0;
   logic [DW-1:0] pix [N];
   logic [DW-1:0] exp_q [$];

   max_pool_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .busy           (busy),
      .maxPoolingDone (maxPoolingDone)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [DW-1:0] m2(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
      return ($signed(a) >= $signed(b)) ? a : b;
`else
      return (a >= b) ? a : b;
`endif
   endfunction

   // Reference: max of each 2x2 block of pix, in raster order of blocks.
   task automatic build_expect();
      exp_q.delete();
      for (int r = 0; r < int'(H); r += 2)
         for (int c = 0; c < int'(W); c += 2)
            exp_q.push_back(m2(m2(pix[r*W + c], pix[r*W + c + 1]),
                               m2(pix[(r+1)*W + c], pix[(r+1)*W + c + 1])));
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Compare process: every output transfer, hold stability, and done timing.
   logic          done_exp = 1'b0;
   logic          stall_v  = 1'b0;
   logic [DW-1:0] stall_d;
   logic          stall_l;
   always @(negedge clk) begin
      if (rst) begin
         done_exp = 1'b0;
         stall_v  = 1'b0;
      end else begin
         chk("done_timing", maxPoolingDone, done_exp);
         done_exp = 1'b0;
         if (!busy) chk("in_ready_not_run", in_ready, 0);
         if (stall_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, stall_d);
            chk("hold_last", out_last, stall_l);
         end
         stall_v = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %0h, required no output", out_data);
               end else begin
                  chk("out_data", out_data, exp_q.pop_front());
                  chk("out_last", out_last, exp_q.size() == 0);
                  if (exp_q.size() == 0) done_exp = 1'b1;
               end
            end else begin
               stall_v = 1'b1;
               stall_d = out_data;
               stall_l = out_last;
            end
         end
      end
   end

   task automatic start_frame();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic feed(input int n, input bit gaps, input int start_at);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = pix[i];
         if (i == start_at) start = 1'b1;
         begin
            int k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!in_ready && k < 200);
            if (!in_ready) chk("in_ready_timeout", 0, 1);
         end
         @(posedge clk); #1;
         start    = 1'b0;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (!maxPoolingDone && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", maxPoolingDone, 1);
      chk("model_drained", exp_q.size(), 0);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", maxPoolingDone, 0);
   endtask

   task automatic run_frame(input bit gaps);
      build_expect();
      start_frame();
      feed(N, gaps, -1);
      wait_done();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", maxPoolingDone, 0);
      rst = 1'b0;

      // Basic ramp frame.
      for (int i = 0; i < int'(N); i++) pix[i] = DW'(i);
      build_expect();
      chk("model_ramp0", exp_q[0], 5);
      chk("model_ramp1", exp_q[1], 7);
      chk("model_ramp2", exp_q[2], 13);
      chk("model_ramp3", exp_q[3], 15);
      run_frame(0);

      // Backpressure: hold the first result for 5 cycles.
      build_expect();
      rdy_mode = 2;
      @(posedge clk); #1;
      start_frame();
      fork
         feed(N, 0, -1);
         begin
            int k = 0;
            while (!out_valid && k < 100) begin
               @(negedge clk);
               k++;
            end
            chk("bp_valid_seen", out_valid, 1);
            repeat (5) begin
               @(negedge clk);
               chk("bp_hold_5", out_data, 5);
               chk("bp_in_ready_low", in_ready, 0);
            end
            rdy_mode = 0;
         end
      join
      wait_done();

      // All pixels at maximum.
      for (int i = 0; i < int'(N); i++) pix[i] = '1;
      build_expect();
      chk("model_all31", exp_q[2], 31);
      run_frame(0);

      // Window {0,0,0,1} and the mixed-sign window.
      for (int i = 0; i < int'(N); i++) pix[i] = '0;
      pix[5] = 5'd1;
      build_expect();
      chk("model_0001", exp_q[0], 1);
      run_frame(0);
      pix[0] = 5'h1F; pix[1] = 5'd3; pix[4] = 5'h10; pix[5] = 5'd0;
      build_expect();
`ifdef MAXPOOL_SIGNED_EN
      chk("model_signed", exp_q[0], 3);
`else
      chk("model_unsigned", exp_q[0], 5'h1F);
`endif
      run_frame(0);

      // Reset mid-frame after 6 pixels, then a clean ramp frame.
      for (int i = 0; i < int'(N); i++) pix[i] = DW'(i);
      build_expect();
      start_frame();
      feed(6, 0, -1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_done", maxPoolingDone, 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", busy, 0);
      end
      run_frame(0);

      // in_valid in IDLE is ignored; start during RUN is ignored.
      in_valid = 1'b1;
      in_data  = 5'd31;
      repeat (4) @(posedge clk);
      #1 in_valid = 1'b0;
      build_expect();
      start_frame();
      feed(N, 0, 3);
      wait_done();

      // Randomized frames with input gaps and random backpressure.
      rdy_mode = 1;
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < int'(N); i++) pix[i] = DW'($urandom_range(0, 31));
         run_frame(1);
      end
      rdy_mode = 0;

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
